core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
Memory-side responder for the CPU core's instruction-fetch and data-access ports. It owns a single-port 64-bit-wide memory array and services instruction fetches and data reads/writes. Each access has a configurable wait-state latency and is acknowledged with a one-cycle valid pulse. It sits in the SoC between the core and on-chip RAM, and arbitrates both ports onto one array.

Parameters:
ADDR_WIDTH, 10, log2 of array depth in 64-bit doublewords (depth 1024 = 8 KiB)
LATENCY, 2, wait cycles between request acceptance and response (0 legal)

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
inst_mem_addr  input  64  instruction byte address from core
inst_addr_valid  input  1  instruction fetch request
inst_mem_valid  output  1  one-cycle ack; inst_mem_data valid this cycle
inst_mem_data  output  32  fetched instruction
data_mem_req  input  1  data access request
data_mem_rw  input  1  1 = write, 0 = read
data_mem_addr  input  64  data byte address
data_mem_be  input  8  byte enables for writes; bit i covers wdata[8i+7:8i]
data_mem_wdata  input  64  write data
data_mem_valid  output  1  one-cycle ack; rdata valid on reads, write committed on writes
data_mem_rdata  output  64  read data
mem_err  output  1  sticky address error flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; inst_mem_valid=0, data_mem_valid=0, inst_mem_data=0, data_mem_rdata=0, mem_err=0. Array contents are not reset.
- Addressing:
  - Doubleword index = addr[ADDR_WIDTH+2:3].
  - Data addr[2:0] is ignored; data accesses are doubleword aligned.
  - Instruction addr[1:0] is ignored. addr[2]=0 selects bits 31:0, addr[2]=1 selects bits 63:32 (little-endian).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if data_mem_req=1, accept the data request; else if inst_addr_valid=1, accept the fetch. Data has fixed priority.
  - On acceptance: latch port select, addr, rw, be and wdata; load the wait counter with LATENCY.
  - IDLE to WAIT when LATENCY>0; IDLE to RESP directly when LATENCY=0.
  - WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, perform the array access and go to RESP.
  - RESP: assert exactly one valid (the latched port's) for one cycle, then go to IDLE unconditionally.
- Latency: a request accepted in cycle t gets valid in cycle t+LATENCY+1. The mandatory IDLE cycle gives a throughput of one access per LATENCY+2 cycles.
- Read data is registered into inst_mem_data / data_mem_rdata on entry to RESP, and holds until the next response.
- Writes: byte-masked per data_mem_be, committed on entry to RESP. be=0x00 is a legal no-op write that still acks.
- Handshake rules:
  - The requester holds its request stable until it sees valid, and presents a new or deasserted request in the cycle after valid.
  - Inputs are ignored outside IDLE.
  - A request withdrawn mid-transaction still completes (write committed, valid pulsed).
- Simultaneous data and instruction requests in IDLE: data is served first. The fetch is accepted in the next IDLE cycle if it is still asserted.
- Reset mid-transaction: return to IDLE, no valid pulse, pending write discarded.

Optional Feature:
- Macro: MEM_BOUND_CHECK_EN.
- When defined, an accepted address with any nonzero bit in [63:ADDR_WIDTH+3]:
  - sets mem_err, which stays set until rst;
  - suppresses the write;
  - returns 0 as read data;
  - still acks after normal latency.
- When undefined, upper address bits are ignored (aliasing) and mem_err is tied 0.

Test Plan:
- LATENCY=2: fetch at addr 0x4 after writing 0x11223344_55667788 to doubleword 0 -> inst_mem_valid 3 cycles after acceptance, inst_mem_data=0x11223344; addr 0x0 returns 0x55667788.
- Write 0xDEADBEEF_CAFEBABE with be=0x0F to addr 0x18 over prior 0 -> read 0x18 gives 0x00000000_CAFEBABE.
- Assert data_mem_req and inst_addr_valid in the same cycle -> data_mem_valid pulses first; inst_mem_valid follows LATENCY+2 cycles later; never both high.
- LATENCY=0: back-to-back reads -> valid every 2nd cycle, each exactly one cycle wide.
- Assert rst during WAIT of a write to 0x20 -> no valid, doubleword 0x20 unchanged, all outputs 0 next cycle.
- MEM_BOUND_CHECK_EN, ADDR_WIDTH=10: write to 0x2000 -> ack, mem_err=1 sticky, doubleword 0 unchanged. Without the macro, the same write lands in doubleword 0 and mem_err=0.

Source files
------------

// File: rtl/core_mem_responder.sv
// core_mem_responder: services the core's instruction-fetch and data ports from
// one single-port 64-bit memory array, with LATENCY wait states per access.
// Optional build macro MEM_BOUND_CHECK_EN flags accesses whose address falls
// beyond the array. With the macro, such an access raises a sticky mem_err,
// drops its write and returns zero data. Without it, upper address bits alias.
module core_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inst_mem_addr,
    input  logic        inst_addr_valid,
    output logic        inst_mem_valid,
    output logic [31:0] inst_mem_data,
    input  logic        data_mem_req,
    input  logic        data_mem_rw,
    input  logic [63:0] data_mem_addr,
    input  logic [7:0]  data_mem_be,
    input  logic [63:0] data_mem_wdata,
    output logic        data_mem_valid,
    output logic [63:0] data_mem_rdata,
    output logic        mem_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   lat_data;
    logic                   lat_rw;
    logic                   lat_hi;
    logic                   lat_oob;
    logic [ADDR_WIDTH-1:0]  lat_idx;
    logic [7:0]             lat_be;
    logic [63:0]            lat_wdata;

    logic [63:0]            mem [DEPTH];

    logic                   req_any_c;
    logic                   sel_oob_c;
    logic [ADDR_WIDTH-1:0]  sel_idx_c;

    logic                   acc_c;
    logic                   acc_data_c;
    logic                   acc_rw_c;
    logic                   acc_hi_c;
    logic                   acc_oob_c;
    logic [ADDR_WIDTH-1:0]  acc_idx_c;
    logic [7:0]             acc_be_c;
    logic [63:0]            acc_wdata_c;
    logic [63:0]            rd_word_c;

    // Byte-offset bits (and upper bits when not bound-checking) are don't-care.
    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{data_mem_addr, inst_mem_addr};

    // Request arbitration in IDLE: data port has fixed priority over fetch.
    always_comb begin
        req_any_c = data_mem_req | inst_addr_valid;
        sel_idx_c = data_mem_req ? data_mem_addr[ADDR_WIDTH+2:3]
                                 : inst_mem_addr[ADDR_WIDTH+2:3];
`ifdef MEM_BOUND_CHECK_EN
        sel_oob_c = data_mem_req ? (|data_mem_addr[63:ADDR_WIDTH+3])
                                 : (|inst_mem_addr[63:ADDR_WIDTH+3]);
`else
        sel_oob_c = 1'b0;
`endif
    end

    // Array access strobe: straight from IDLE at zero latency, else at end of WAIT.
    always_comb begin
        acc_c       = 1'b0;
        acc_data_c  = lat_data;
        acc_rw_c    = lat_rw;
        acc_hi_c    = lat_hi;
        acc_oob_c   = lat_oob;
        acc_idx_c   = lat_idx;
        acc_be_c    = lat_be;
        acc_wdata_c = lat_wdata;
        if (state == IDLE) begin
            acc_c       = (LATENCY == 0) && req_any_c;
            acc_data_c  = data_mem_req;
            acc_rw_c    = data_mem_req & data_mem_rw;
            acc_hi_c    = inst_mem_addr[2];
            acc_oob_c   = sel_oob_c;
            acc_idx_c   = sel_idx_c;
            acc_be_c    = data_mem_be;
            acc_wdata_c = data_mem_wdata;
        end else if (state == WAIT) begin
            acc_c = (cnt == CNT_W'(1));
        end
        rd_word_c = mem[acc_idx_c];
    end

    // Byte-masked array write; a reset in the same cycle discards it.
    always_ff @(posedge clk) begin
        if (!rst && acc_c && acc_data_c && acc_rw_c && !acc_oob_c) begin
            for (int i = 0; i < 8; i++) begin
                if (acc_be_c[i]) begin
                    mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered acks, read data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_data       <= 1'b0;
            lat_rw         <= 1'b0;
            lat_hi         <= 1'b0;
            lat_oob        <= 1'b0;
            lat_idx        <= '0;
            lat_be         <= '0;
            lat_wdata      <= '0;
            inst_mem_valid <= 1'b0;
            inst_mem_data  <= '0;
            data_mem_valid <= 1'b0;
            data_mem_rdata <= '0;
            mem_err        <= 1'b0;
        end else begin
            inst_mem_valid <= 1'b0;
            data_mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any_c) begin
                        lat_data  <= data_mem_req;
                        lat_rw    <= data_mem_req & data_mem_rw;
                        lat_hi    <= inst_mem_addr[2];
                        lat_oob   <= sel_oob_c;
                        lat_idx   <= sel_idx_c;
                        lat_be    <= data_mem_be;
                        lat_wdata <= data_mem_wdata;
                        cnt       <= CNT_W'(LATENCY);
                        mem_err   <= mem_err | sel_oob_c;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (acc_c) begin
                if (acc_data_c) begin
                    data_mem_valid <= 1'b1;
                    if (!acc_rw_c) begin
                        data_mem_rdata <= acc_oob_c ? 64'h0 : rd_word_c;
                    end
                end else begin
                    inst_mem_valid <= 1'b1;
                    inst_mem_data  <= acc_oob_c ? 32'h0
                                    : (acc_hi_c ? rd_word_c[63:32] : rd_word_c[31:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Testbench for core_mem_responder: directed and random traffic on a LATENCY=2
// instance plus back-to-back traffic on a LATENCY=0 instance, against an
// array-based reference model. Honours MEM_BOUND_CHECK_EN when defined.
module tb_core_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] i_addr = '0;
    logic        i_valid = 1'b0;
    logic        i_mvalid;
    logic [31:0] i_data;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b0;
    logic [63:0] d_addr = '0;
    logic [7:0]  d_be = '0;
    logic [63:0] d_wdata = '0;
    logic        d_valid;
    logic [63:0] d_rdata;
    logic        merr;

    logic        z_ivalid;
    logic [31:0] z_idata;
    logic        z_req = 1'b0;
    logic        z_rw = 1'b0;
    logic [63:0] z_addr = '0;
    logic [63:0] z_wdata = '0;
    logic        z_dvalid;
    logic [63:0] z_rdata;
    logic        z_merr;

    int errors = 0;
    int checks = 0;

    logic [63:0] mdl  [1024];
    logic [63:0] mdl0 [1024];
    bit          exp_err = 1'b0;

    always #5 clk = ~clk;

    core_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .inst_mem_addr(i_addr), .inst_addr_valid(i_valid),
        .inst_mem_valid(i_mvalid), .inst_mem_data(i_data),
        .data_mem_req(d_req), .data_mem_rw(d_rw), .data_mem_addr(d_addr),
        .data_mem_be(d_be), .data_mem_wdata(d_wdata),
        .data_mem_valid(d_valid), .data_mem_rdata(d_rdata), .mem_err(merr)
    );

    core_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .inst_mem_addr(64'h0), .inst_addr_valid(1'b0),
        .inst_mem_valid(z_ivalid), .inst_mem_data(z_idata),
        .data_mem_req(z_req), .data_mem_rw(z_rw), .data_mem_addr(z_addr),
        .data_mem_be(8'hFF), .data_mem_wdata(z_wdata),
        .data_mem_valid(z_dvalid), .data_mem_rdata(z_rdata), .mem_err(z_merr)
    );

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oob(input logic [63:0] a);
`ifdef MEM_BOUND_CHECK_EN
        return (a / 64'd8192) != 64'd0;
`else
        return 1'b0 & a[0];
`endif
    endfunction

    function automatic int unsigned idx_of(input logic [63:0] a);
        return 32'((a / 64'd8) % 64'd1024);
    endfunction

    function automatic void mdl_write(input logic [63:0] a, input logic [7:0] be, input logic [63:0] wd);
        int unsigned ix = idx_of(a);
        if (!is_oob(a)) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mdl[ix][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endfunction

    function automatic logic [63:0] mdl_rd(input logic [63:0] a);
        return is_oob(a) ? 64'h0 : mdl[idx_of(a)];
    endfunction

    function automatic logic [31:0] mdl_fetch(input logic [63:0] a);
        logic [63:0] w = mdl_rd(a);
        return ((a / 64'd4) % 64'd2 == 64'd1) ? w[63:32] : w[31:0];
    endfunction

    // Wait for the wanted port's ack; the other port must stay quiet.
    task automatic wait_ack(input bit want_data, output int k);
        bit found = 1'b0;
        k = 0;
        while (!found && k < 32) begin
            @(negedge clk);
            k++;
            check("both_valid", 64'(d_valid & i_mvalid), 64'h0);
            if (want_data ? d_valid : i_mvalid) found = 1'b1;
            else check("early_valid", 64'(d_valid | i_mvalid), 64'h0);
        end
    endtask

    task automatic data_op(input logic rw, input logic [63:0] a, input logic [7:0] be,
                           input logic [63:0] wd, output logic [63:0] rd);
        int k;
        d_req = 1'b1; d_rw = rw; d_addr = a; d_be = be; d_wdata = wd;
        if (rw) mdl_write(a, be, wd);
        exp_err = exp_err | is_oob(a);
        wait_ack(1'b1, k);
        rd = d_rdata;
        check("d_latency", 64'(k), 64'(LAT + 1));
        d_req = 1'b0; d_rw = 1'(~rw); d_wdata = ~wd;
        @(negedge clk);
        check("d_pulse", 64'(d_valid | i_mvalid), 64'h0);
        check("mem_err", 64'(merr), 64'(exp_err));
    endtask

    task automatic inst_op(input logic [63:0] a, output logic [31:0] rd);
        int k;
        i_valid = 1'b1; i_addr = a;
        exp_err = exp_err | is_oob(a);
        wait_ack(1'b0, k);
        rd = i_data;
        check("i_latency", 64'(k), 64'(LAT + 1));
        i_valid = 1'b0;
        @(negedge clk);
        check("i_pulse", 64'(d_valid | i_mvalid), 64'h0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [31:0] ird;
        logic [63:0] a;
        int          kd, ki, k;
        logic [63:0] sd;
        logic [31:0] si;
        bit          op_rw [16];
        int unsigned op_idx [16];
        logic [63:0] op_wd [16];
        logic [63:0] z_exp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_d_valid", 64'(d_valid), 64'h0);
        check("rst_i_valid", 64'(i_mvalid), 64'h0);
        check("rst_d_rdata", d_rdata, 64'h0);
        check("rst_i_data", 64'(i_data), 64'h0);
        check("rst_mem_err", 64'(merr), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Instruction word select within a doubleword
        data_op(1'b1, 64'h0, 8'hFF, 64'h11223344_55667788, rd);
        inst_op(64'h4, ird);
        check("fetch_hi", 64'(ird), 64'h11223344);
        inst_op(64'h0, ird);
        check("fetch_lo", 64'(ird), 64'h55667788);
        inst_op(64'h7, ird);
        check("fetch_hi_lowbits", 64'(ird), 64'(mdl_fetch(64'h7)));

        // Partial byte-enable write over zero
        data_op(1'b1, 64'h18, 8'hFF, 64'h0, rd);
        data_op(1'b1, 64'h18, 8'h0F, 64'hDEADBEEF_CAFEBABE, rd);
        data_op(1'b0, 64'h18, 8'h00, 64'h0, rd);
        check("be_merge", rd, 64'h00000000_CAFEBABE);
        data_op(1'b1, 64'h1D, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        data_op(1'b0, 64'h18, 8'h00, 64'h0, rd);
        check("be_zero_noop", rd, 64'h00000000_CAFEBABE);

        // Fill a working set, then random traffic
        for (int i = 0; i < 64; i++) begin
            data_op(1'b1, 64'(i) * 64'd8, 8'hFF, {$urandom, $urandom}, rd);
        end
        for (int n = 0; n < 120; n++) begin
            a = 64'($urandom_range(0, 63)) * 64'd8 + 64'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: begin
                    data_op(1'b0, a, 8'($urandom), 64'h0, rd);
                    check("rand_read", rd, mdl_rd(a));
                end
                1: data_op(1'b1, a, 8'($urandom), {$urandom, $urandom}, rd);
                default: begin
                    inst_op(a, ird);
                    check("rand_fetch", 64'(ird), 64'(mdl_fetch(a)));
                end
            endcase
        end

        // Simultaneous requests: data first, fetch LAT+2 cycles later
        d_req = 1'b1; d_rw = 1'b0; d_addr = 64'h28; i_valid = 1'b1; i_addr = 64'h34;
        kd = 0; ki = 0; k = 0; sd = '0; si = '0;
        while (ki == 0 && k < 40) begin
            @(negedge clk);
            k++;
            check("sim_both", 64'(d_valid & i_mvalid), 64'h0);
            if (d_valid && kd == 0) begin kd = k; sd = d_rdata; d_req = 1'b0; end
            if (i_mvalid) begin ki = k; si = i_data; i_valid = 1'b0; end
        end
        check("sim_d_lat", 64'(kd), 64'(LAT + 1));
        check("sim_i_gap", 64'(ki - kd), 64'(LAT + 2));
        check("sim_d_data", sd, mdl_rd(64'h28));
        check("sim_i_data", 64'(si), 64'(mdl_fetch(64'h34)));
        @(negedge clk);

        // Zero-latency instance: back-to-back ops, ack every other cycle
        for (int i = 0; i < 16; i++) begin
            op_rw[i]  = (i < 8);
            op_idx[i] = (i < 8) ? 32'(i) : $urandom_range(0, 7);
            op_wd[i]  = {$urandom, $urandom};
        end
        z_exp = '0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("l0_valid", 64'(z_dvalid), 64'h1);
                if (!op_rw[i-1]) check("l0_rdata", z_rdata, z_exp);
            end
            if (i < 16) begin
                z_req = 1'b1; z_rw = op_rw[i];
                z_addr = 64'(op_idx[i]) * 64'd8; z_wdata = op_wd[i];
                if (op_rw[i]) mdl0[op_idx[i]] = op_wd[i];
                else z_exp = mdl0[op_idx[i]];
            end else begin
                z_req = 1'b0;
            end
            if (i > 0) begin
                @(negedge clk);
                check("l0_gap", 64'(z_dvalid | z_ivalid), 64'h0);
            end
        end
        check("l0_mem_err", 64'(z_merr), 64'h0);
        check("l0_idata", 64'(z_idata), 64'h0);

        // Reset during the final wait cycle of a write
        d_req = 1'b1; d_rw = 1'b1; d_addr = 64'h20; d_be = 8'hFF; d_wdata = 64'h0BAD_F00D_0BAD_F00D;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("rst_wait_valid", 64'(d_valid), 64'h0);
        end
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        check("mid_rst_d_valid", 64'(d_valid), 64'h0);
        check("mid_rst_i_valid", 64'(i_mvalid), 64'h0);
        check("mid_rst_d_rdata", d_rdata, 64'h0);
        check("mid_rst_i_data", 64'(i_data), 64'h0);
        check("mid_rst_mem_err", 64'(merr), 64'h0);
        @(negedge clk);
        check("mid_rst_no_ack", 64'(d_valid), 64'h0);
        data_op(1'b0, 64'h20, 8'h00, 64'h0, rd);
        check("mid_rst_no_write", rd, mdl_rd(64'h20));

        // Out-of-range address: flagged and dropped, or aliased onto doubleword 0
        data_op(1'b1, 64'h2000, 8'hFF, 64'hA5A5_5A5A_C3C3_3C3C, rd);
        data_op(1'b0, 64'h0, 8'h00, 64'h0, rd);
        check("bound_dw0", rd, mdl_rd(64'h0));
        data_op(1'b0, 64'h2000, 8'h00, 64'h0, rd);
        check("bound_read", rd, mdl_rd(64'h2000));
        inst_op(64'h2004, ird);
        check("bound_fetch", 64'(ird), 64'(mdl_fetch(64'h2004)));
        data_op(1'b0, 64'h8, 8'h00, 64'h0, rd);
        check("bound_after", rd, mdl_rd(64'h8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
